// File: rtl/mouse_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets and integrates the motion deltas
// into a clamped absolute cursor position.
module mouse_packet_assembler #(
    parameter int X_MAX          = 160,
    parameter int Y_MAX          = 120,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic       BYTE_READY,
    input  logic [1:0] BYTE_ERROR_CODE,
    output logic       RX_READ_ENABLE,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       PACKET_VALID,
    output logic       SYNC_ERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [10:0] X_LIM = 11'(X_MAX - 1);
    localparam logic signed [10:0] Y_LIM = 11'(Y_MAX - 1);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] timeout_cnt;
    logic [7:0] status_b, byte1, byte2;
    logic byte_ok, in_body, timeout_hit;
    logic capture_b0, capture_b1, capture_b2, sync_err_set, load_outputs;
    logic signed [10:0] dx_ext, dy_ext, x_sum, y_sum;

    function automatic logic [7:0] clamp_pos(input logic signed [10:0] v,
                                             input logic signed [10:0] lim);
        if (v < 11'sd0)
            clamp_pos = 8'd0;
        else if (v > lim)
            clamp_pos = lim[7:0];
        else
            clamp_pos = v[7:0];
    endfunction

    assign byte_ok     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign in_body     = (state == WAIT_B1) || (state == WAIT_B2);
    assign timeout_hit = in_body && !BYTE_READY && (timeout_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= WAIT_B0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!ENABLE) begin
            state_next = WAIT_B0;
        end else begin
            case (state)
                WAIT_B0: if (byte_ok && BYTE_READ[3]) state_next = WAIT_B1;
                WAIT_B1: begin
                    if (BYTE_READY)
                        state_next = byte_ok ? WAIT_B2 : WAIT_B0;
                    else if (timeout_hit)
                        state_next = WAIT_B0;
                end
                WAIT_B2: begin
                    if (BYTE_READY)
                        state_next = byte_ok ? UPDATE : WAIT_B0;
                    else if (timeout_hit)
                        state_next = WAIT_B0;
                end
                UPDATE:  state_next = WAIT_B0;
                default: state_next = WAIT_B0;
            endcase
        end
    end

    always_comb begin
        capture_b0   = 1'b0;
        capture_b1   = 1'b0;
        capture_b2   = 1'b0;
        sync_err_set = 1'b0;
        load_outputs = (state == UPDATE);
        if (ENABLE) begin
            case (state)
                WAIT_B0: begin
                    capture_b0   = byte_ok && BYTE_READ[3];
                    sync_err_set = byte_ok && !BYTE_READ[3];
                end
                WAIT_B1: capture_b1 = byte_ok;
                WAIT_B2: capture_b2 = byte_ok;
                default: ;
            endcase
        end
    end

    // Inter-byte timeout: restarts on any strobe, only runs mid-packet
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            timeout_cnt <= '0;
        else if (!ENABLE || BYTE_READY || !in_body || timeout_hit)
            timeout_cnt <= '0;
        else
            timeout_cnt <= timeout_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (capture_b0) status_b <= BYTE_READ;
        if (capture_b1) byte1    <= BYTE_READ;
        if (capture_b2) byte2    <= BYTE_READ;
    end

    // Overflow flags suppress the corresponding delta entirely
    always_comb begin
        dx_ext = status_b[6] ? 11'sd0 : {{3{status_b[4]}}, byte1};
        dy_ext = status_b[7] ? 11'sd0 : {{3{status_b[5]}}, byte2};
        x_sum  = $signed({3'b000, MOUSE_X}) + dx_ext;
        y_sum  = $signed({3'b000, MOUSE_Y}) - dy_ext;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MOUSE_X        <= 8'(X_MAX / 2);
            MOUSE_Y        <= 8'(Y_MAX / 2);
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
            PACKET_VALID   <= 1'b0;
            SYNC_ERR       <= 1'b0;
            RX_READ_ENABLE <= 1'b0;
        end else begin
            PACKET_VALID   <= load_outputs;
            SYNC_ERR       <= sync_err_set;
            RX_READ_ENABLE <= ENABLE;
            if (load_outputs) begin
                MOUSE_X      <= clamp_pos(x_sum, X_LIM);
                MOUSE_Y      <= clamp_pos(y_sum, Y_LIM);
                MOUSE_STATUS <= status_b;
                MOUSE_DX     <= byte1;
                MOUSE_DY     <= byte2;
            end
        end
    end

endmodule

// File: doc/mouse_packet_assembler.md
MOUSE_PACKET_ASSEMBLER -- requirements
Module: mouse_packet_assembler

Interface
REQ-001 SHALL have parameter X_MAX, default 160, horizontal position range [0, X_MAX-1].
REQ-002 SHALL have parameter Y_MAX, default 120, vertical position range [0, Y_MAX-1].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, inter-byte timeout in CLK cycles.
REQ-004 SHALL have ports:
- CLK  in  1  clock.
- RESET  in  1  reset: asynchronous, active-low.
- ENABLE  in  1  stream decoding enable.
- BYTE_READ  in  8  received byte from the PS/2 byte receiver.
- BYTE_READY  in  1  single-cycle strobe; BYTE_READ is valid.
- BYTE_ERROR_CODE  in  2  receiver error flags, sampled with BYTE_READY.
- RX_READ_ENABLE  out  1  read enable to the receiver.
- MOUSE_X  out  8  absolute X position.
- MOUSE_Y  out  8  absolute Y position, 0 = top.
- MOUSE_STATUS  out  8  byte 0 of the last accepted packet.
- MOUSE_DX  out  8  raw byte 1 of the last accepted packet.
- MOUSE_DY  out  8  raw byte 2 of the last accepted packet.
- PACKET_VALID  out  1  one-cycle pulse when outputs update.
- SYNC_ERR  out  1  one-cycle pulse when a byte 0 is rejected.

Function
REQ-005 SHALL implement the FSM WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> UPDATE -> WAIT_B0, one-hot or binary.
REQ-006 SHALL accept a byte only in a cycle where BYTE_READY=1; other cycles do not advance byte-wait states.
REQ-007 WAIT_B0: byte with bit3=1 and error code 00 SHALL be stored as status and SHALL move the FSM to WAIT_B1.
REQ-008 WAIT_B0: byte with bit3=0 SHALL be discarded, the FSM SHALL stay in WAIT_B0, and SYNC_ERR SHALL pulse the next cycle.
REQ-009 Any byte with BYTE_ERROR_CODE != 00 SHALL abort the packet: return to WAIT_B0, no output change, no PACKET_VALID.
REQ-010 WAIT_B1/WAIT_B2: each accepted byte SHALL be stored and SHALL advance the FSM; WAIT_B2 advances to UPDATE.
REQ-011 Inter-byte timeout:
- A counter SHALL reset on every BYTE_READY and count while in WAIT_B1 or WAIT_B2.
- On reaching TIMEOUT_CYCLES-1 the FSM SHALL return to WAIT_B0 and the partial packet SHALL be discarded.
- Counter width SHALL be clog2(TIMEOUT_CYCLES).
REQ-012 UPDATE SHALL last exactly one cycle; a BYTE_READY arriving in UPDATE SHALL be ignored.
REQ-013 dx SHALL be the 9-bit signed value {status[4], byte1}; dy SHALL be {status[5], byte2}.
REQ-014 If status[6] (X overflow) is set, dx SHALL be treated as 0; if status[7] (Y overflow) is set, dy SHALL be treated as 0.
REQ-015 Position arithmetic:
- Computed in 11-bit signed.
- X_new = X + dx, clamped to [0, X_MAX-1].
- Y_new = Y - dy, clamped to [0, Y_MAX-1] (PS/2 positive dy is up).
REQ-016 On the clock edge ending UPDATE, the following SHALL be registered together: MOUSE_X, MOUSE_Y, MOUSE_STATUS, MOUSE_DX, MOUSE_DY; PACKET_VALID=1 for that one cycle.
REQ-017 Latency: PACKET_VALID SHALL be high in cycle N+2 when byte 2's BYTE_READY is in cycle N.
REQ-018 ENABLE=0 SHALL synchronously force WAIT_B0, clear the timeout counter, and discard the partial packet; positions and other outputs are retained.
REQ-019 RX_READ_ENABLE SHALL be ENABLE registered once.
REQ-020 SYNC_ERR and PACKET_VALID SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-021 RESET low SHALL asynchronously set the following:
- state WAIT_B0; timeout counter 0.
- MOUSE_X = X_MAX/2 (80); MOUSE_Y = Y_MAX/2 (60).
- MOUSE_STATUS, MOUSE_DX, MOUSE_DY = 0x00.
- PACKET_VALID, SYNC_ERR, RX_READ_ENABLE = 0.
REQ-022 Reset asserted mid-packet SHALL discard the partial packet; the first packet after release SHALL decode normally.

Verification
REQ-023 Basic packet: reset, ENABLE=1, bytes 0x08, 0x05, 0x03 -> MOUSE_X=85, MOUSE_Y=57, MOUSE_STATUS=0x08; PACKET_VALID one pulse, 2 cycles after the third BYTE_READY.
REQ-024 Clamp: from X=80, bytes 0x18, 0x9C, 0x00 (dx=-100) -> MOUSE_X=0; then 0x08, 0x7F, 0x00 repeated twice -> MOUSE_X=159.
REQ-025 Resync: byte 0x00 in WAIT_B0 -> SYNC_ERR pulse, state unchanged; following 0x08, 0x01, 0x01 -> MOUSE_X=81, MOUSE_Y=59.
REQ-026 Timeout: 0x08, 0x10, then idle TIMEOUT_CYCLES -> WAIT_B0, no PACKET_VALID; next 0x08, 0x02, 0x00 -> MOUSE_X=82.
REQ-027 Error and overflow:
- Byte 1 with BYTE_ERROR_CODE=01 -> packet dropped, outputs unchanged.
- Bytes 0x48, 0xFF, 0x00 -> PACKET_VALID, MOUSE_X unchanged, MOUSE_DX=0xFF.
REQ-028 Mid-packet ENABLE/RESET: ENABLE low after byte 1 -> packet discarded; RESET pulse after byte 1 -> outputs at reset values; a subsequent full packet decodes correctly.
